// File: rtl/lz_decompressor.sv
// LZ77 token decoder: turns (distance, length, literal) tokens back into a
// byte stream, one byte per cycle, using a circular history of the last
// Q_LENGTH emitted bytes as the sliding dictionary.
module lz_decompressor #(
    parameter int Q_LENGTH = 10,
    parameter int Q_BITS   = 4,
    parameter int L_LENGTH = 10,
    parameter int L_BITS   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              token_valid,
    output logic              token_ready,
    input  logic [Q_BITS:0]   distance,
    input  logic [L_BITS:0]   length,
    input  logic [7:0]        literal,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              ref_error
);

    typedef enum logic [1:0] {IDLE, COPY, LIT} state_t;

    localparam logic [Q_BITS-1:0] LAST_IDX = Q_BITS'(Q_LENGTH - 1);
    localparam logic [Q_BITS-1:0] Q_IDX    = Q_BITS'(Q_LENGTH);
    localparam logic [Q_BITS:0]   Q_FULL   = (Q_BITS+1)'(Q_LENGTH);
    localparam logic [L_BITS:0]   L_MAX    = (L_BITS+1)'(L_LENGTH);
    localparam logic [L_BITS:0]   ONE_LEFT = (L_BITS+1)'(1);

    state_t            state;
    logic [7:0]        history [0:Q_LENGTH-1];
    logic [Q_BITS-1:0] wr;
    logic [Q_BITS-1:0] rd;
    logic [Q_BITS:0]   fill;
    logic [L_BITS:0]   count;
    logic [7:0]        lit_reg;

    logic              accept;
    logic              xfer;
    logic              legal;
    logic [Q_BITS-1:0] dist_lo;
    logic [Q_BITS-1:0] rd_start;
    logic [Q_BITS-1:0] wr_inc;
    logic [Q_BITS-1:0] rd_inc;

    assign accept  = token_valid && token_ready;
    assign xfer    = out_valid && out_ready;
    assign dist_lo = distance[Q_BITS-1:0];
    assign legal   = (distance != '0) && (distance <= fill) && (length <= L_MAX);
    assign wr_inc  = (wr == LAST_IDX) ? '0 : wr + 1'b1;
    assign rd_inc  = (rd == LAST_IDX) ? '0 : rd + 1'b1;

    // Start of the back-reference: (wr - distance) mod Q_LENGTH, folded with
    // a conditional add so no divider is needed. Only meaningful when legal.
    always_comb begin
        rd_start = wr - dist_lo;
        if ({1'b0, wr} < distance) begin
            rd_start = wr + Q_IDX - dist_lo;
        end
    end

    // History write: every byte that leaves the decoder is remembered.
    always_ff @(posedge clock) begin
        if (xfer) begin
            history[wr] <= out_byte;
        end
    end

    // Token FSM with registered outputs plus write-pointer / fill tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            token_ready <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_byte    <= '0;
            ref_error   <= 1'b0;
            wr          <= '0;
            rd          <= '0;
            fill        <= '0;
            count       <= '0;
            lit_reg     <= '0;
        end else begin
            if (xfer) begin
                wr <= wr_inc;
                if (fill != Q_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        lit_reg     <= literal;
                        count       <= length;
                        rd          <= rd_start;
                        token_ready <= 1'b0;
                        out_valid   <= 1'b1;
                        if (length != '0 && legal) begin
                            state    <= COPY;
                            out_byte <= history[rd_start];
                            out_last <= 1'b0;
                        end else begin
                            // Illegal copies are dropped; the literal still goes out.
                            state    <= LIT;
                            out_byte <= literal;
                            out_last <= 1'b1;
                            if (length != '0) begin
                                ref_error <= 1'b1;
                            end
                        end
                    end
                end
                COPY: begin
                    if (xfer) begin
                        rd    <= rd_inc;
                        count <= count - 1'b1;
                        if (count == ONE_LEFT) begin
                            state    <= LIT;
                            out_byte <= lit_reg;
                            out_last <= 1'b1;
                        end else if (rd_inc == wr) begin
                            // Next read hits the slot being written right now
                            // (distance 1): forward the byte instead of the stale RAM.
                            out_byte <= out_byte;
                        end else begin
                            out_byte <= history[rd_inc];
                        end
                    end
                end
                LIT: begin
                    if (xfer) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        out_byte    <= '0;
                        token_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lz_decompressor.sv
// Directed bench for lz_decompressor: literal/copy tokens, overlap, wrap,
// backpressure, illegal references and asynchronous reset mid-copy.
module tb_lz_decompressor;

    logic       clock;
    logic       reset;
    logic       token_valid;
    logic       token_ready;
    logic [4:0] distance;
    logic [4:0] length;
    logic [7:0] literal;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       ref_error;

    int total;
    int bad;

    lz_decompressor #(
        .Q_LENGTH(10), .Q_BITS(4), .L_LENGTH(10), .L_BITS(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .token_valid (token_valid),
        .token_ready (token_ready),
        .distance    (distance),
        .length      (length),
        .literal     (literal),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .ref_error   (ref_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        token_valid = 1'b0;
        out_ready   = 1'b1;
        reset       = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Present one token and let it be accepted; returns #1 after the accept edge.
    task automatic send_token(input logic [4:0] d, input logic [4:0] l, input logic [7:0] lit);
        int waited;
        waited = 0;
        while (!token_ready && waited < 40) begin
            step();
            waited++;
        end
        check_val("token_ready_wait", 8'(token_ready), 8'd1);
        distance    = d;
        length      = l;
        literal     = lit;
        token_valid = 1'b1;
        step();
        token_valid = 1'b0;
        $display("token d=%0d l=%0d lit=%h", d, l, lit);
        check_val("first_byte_latency", 8'(out_valid), 8'd1);
    endtask

    // Expect a byte on the output right now, then let it transfer.
    task automatic recv(input logic [7:0] exp_byte, input logic exp_last);
        check_val("out_valid", 8'(out_valid), 8'd1);
        check_val("out_byte", out_byte, exp_byte);
        check_val("out_last", 8'(out_last), 8'(exp_last));
        $display("byte %h last=%0d", out_byte, out_last);
        step();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        distance    = '0;
        length      = '0;
        literal     = '0;
        token_valid = 1'b0;
        out_ready   = 1'b1;
        reset       = 1'b0;
        step();
        // Reset state
        check_val("rst_token_ready", 8'(token_ready), 8'd1);
        check_val("rst_out_valid", 8'(out_valid), 8'd0);
        check_val("rst_out_last", 8'(out_last), 8'd0);
        check_val("rst_out_byte", out_byte, 8'd0);
        check_val("rst_ref_error", 8'(ref_error), 8'd0);
        reset = 1'b1;
        step();

        // Literals then a back-reference
        send_token(5'd0, 5'd0, "A"); recv("A", 1'b1);
        send_token(5'd0, 5'd0, "B"); recv("B", 1'b1);
        send_token(5'd0, 5'd0, "C"); recv("C", 1'b1);
        send_token(5'd3, 5'd3, "D");
        recv("A", 1'b0); recv("B", 1'b0); recv("C", 1'b0); recv("D", 1'b1);
        check_val("lit_ref_error", 8'(ref_error), 8'd0);
        check_val("idle_after_token", 8'(out_valid), 8'd0);

        // Overlapping copy, distance 1
        do_reset();
        send_token(5'd0, 5'd0, "A"); recv("A", 1'b1);
        send_token(5'd1, 5'd4, "B");
        recv("A", 1'b0); recv("A", 1'b0); recv("A", 1'b0); recv("A", 1'b0);
        recv("B", 1'b1);
        check_val("overlap_ref_error", 8'(ref_error), 8'd0);

        // History wrap
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send_token(5'd0, 5'd0, 8'(8'h30 + i));
            recv(8'(8'h30 + i), 1'b1);
        end
        send_token(5'd10, 5'd3, 8'h41);
        recv(8'h31, 1'b0); recv(8'h32, 1'b0); recv(8'h33, 1'b0); recv(8'h41, 1'b1);
        // wr=5 now; distance 7 starts at index 8 and the read crosses 9 -> 0
        send_token(5'd7, 5'd3, 8'h42);
        recv(8'h38, 1'b0); recv(8'h39, 1'b0); recv(8'h3A, 1'b0); recv(8'h42, 1'b1);
        check_val("wrap_ref_error", 8'(ref_error), 8'd0);

        // Backpressure on the first copied byte
        do_reset();
        send_token(5'd0, 5'd0, "A"); recv("A", 1'b1);
        send_token(5'd0, 5'd0, "B"); recv("B", 1'b1);
        send_token(5'd0, 5'd0, "C"); recv("C", 1'b1);
        send_token(5'd3, 5'd3, "D");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("bp_valid", 8'(out_valid), 8'd1);
            check_val("bp_byte", out_byte, "A");
            check_val("bp_last", 8'(out_last), 8'd0);
            step();
        end
        out_ready = 1'b1;
        recv("A", 1'b0); recv("B", 1'b0); recv("C", 1'b0); recv("D", 1'b1);

        // Illegal reference with fill=2, then a legal one
        do_reset();
        send_token(5'd0, 5'd0, "a"); recv("a", 1'b1);
        send_token(5'd0, 5'd0, "b"); recv("b", 1'b1);
        send_token(5'd5, 5'd2, "Z"); recv("Z", 1'b1);
        check_val("illegal_ref_error", 8'(ref_error), 8'd1);
        send_token(5'd1, 5'd1, "Q"); recv("Z", 1'b0); recv("Q", 1'b1);
        check_val("sticky_ref_error", 8'(ref_error), 8'd1);

        // Asynchronous reset during the second byte of a copy
        do_reset();
        check_val("reset_clears_error", 8'(ref_error), 8'd0);
        send_token(5'd0, 5'd0, "a"); recv("a", 1'b1);
        send_token(5'd0, 5'd0, "b"); recv("b", 1'b1);
        send_token(5'd0, 5'd0, "c"); recv("c", 1'b1);
        send_token(5'd3, 5'd3, "D");
        recv("a", 1'b0);
        check_val("mid_copy_byte", out_byte, "b");
        reset = 1'b0;
        #1;
        check_val("async_out_valid", 8'(out_valid), 8'd0);
        check_val("async_token_ready", 8'(token_ready), 8'd1);
        step();
        reset = 1'b1;
        step();
        send_token(5'd1, 5'd1, "X"); recv("X", 1'b1);
        check_val("post_reset_ref_error", 8'(ref_error), 8'd1);
        check_val("post_reset_idle", 8'(out_valid), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
